ov7670_camera_ctrl: RTL and testbench
=====================================

Name: ov7670_camera_ctrl

Overview:
Single-clock OV7670 front end with two jobs. It configures the sensor over SCCB (I2C-like, write-only) from a fixed register table, and it captures the parallel 8-bit pixel bus into 16-bit RGB565 words. Camera pins (p_clk, vsync, href, p_data) are oversampled in the clk domain. Outputs feed a frame-buffer writer that stores pixel_data on pixel_valid.

Parameters:
CLK_HZ, 100_000_000, frequency of clk; must be at least 4x the camera pixel clock.
SCCB_HZ, 100_000, SIOC frequency; quarter period = CLK_HZ/(4*SCCB_HZ) cycles.
RESET_WAIT_CYC, 100_000, idle cycles after writing COM7=0x80 (soft reset) before the next table entry.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  rising edge starts sensor configuration
p_clk  in  1  camera pixel clock, asynchronous; sampled as data
vsync  in  1  camera frame sync, high between frames
href  in  1  camera line valid
p_data  in  8  camera pixel byte
sioc  out  1  SCCB clock
siod  out  1  SCCB data, push-pull
done  out  1  configuration complete, level
pixel_data  out  16  {first byte, second byte} of a pixel
pixel_valid  out  1  one-cycle strobe; pixel_data valid
frame_done  out  1  one-cycle strobe at end of frame

Behaviour:
- Reset values: sioc=1, siod=1, done=0, pixel_data=0, pixel_valid=0, frame_done=0. Config FSM returns to IDLE and the capture logic disarms. A reset in the middle of a transaction abandons it immediately with no stop condition.
- Config FSM states and transitions:
  - IDLE: waits for a start rising edge.
  - LOAD: fetches table[idx].
  - START: siod falls while sioc is high, then sioc falls.
  - SHIFT: 27 bits in three 9-bit phases: 0x42, register address, register data. Each phase sends 8 bits MSB-first, then one don't-care bit with siod=1.
  - STOP: siod low, sioc rises, siod rises.
  - GAP: at least one SCCB period idle.
  - WAIT: entered after the 0x12/0x80 entry; lasts RESET_WAIT_CYC.
  - DONE.
- SCCB bit timing: siod changes only while sioc is low. Each bit occupies four quarter periods: low, low, high, high.
- No ACK checking.
- done rises after the last entry's STOP and holds. A new start rising edge in DONE clears done and reruns the table from idx 0. start is ignored while busy.
- Capture front end: p_clk, vsync, href, p_data pass through 2-FF synchronizers aligned stage-for-stage. A p_clk rising edge is detected on the synced signal.
- Capture enable and arming:
  - Capture is enabled only while done=1.
  - Arming happens on the first synced vsync falling edge after done, so partial frames are dropped.
- Byte assembly:
  - On each p_clk edge with href=1, bytes alternate: the first goes to [15:8], the second to [7:0].
  - Completing the second byte loads pixel_data and pulses pixel_valid for one clk. Latency is 3 clk from the pin edge to the strobe.
  - When href=0, the byte phase resets to "first" and an odd dangling byte is discarded.
- frame_done: one-cycle pulse on a synced vsync rising edge while armed. Capture stays armed for the following frames.
- If a pixel completion and frame_done fall on the same cycle, both strobes assert.
- If done drops (restart), capture disarms immediately.

Optional Feature:
CAM_TEST_PATTERN_EN
- Defined: the table appends 0x70=0x3A, 0x71=0xB5 (8-bar color bar) after the normal entries, so the table is longer and done comes later.
- Undefined: normal table only.
- The capture path is identical either way.

Decomposition:
- Package ov7670_pkg holds:
  - SCCB_ID=0x42
  - register table as (addr,data) pairs: 0x12/0x80 first, 0x12/0x04 RGB, 0x40/0xD0 RGB565 full range, 0x8C/0x00, 0x3A/0x04, 0x11/0x01 prescaler, QVGA 0x0C/0x04 and 0x3E/0x19
  - TABLE_LEN
  - config FSM state enum
- One sub-module, sccb_writer. Interface: go, addr[7:0], data[7:0] in; busy/ack out; drives sioc/siod. The table sequencer and capture logic stay in the top.

Test Plan:
- Reset, then hold rst_n=0 mid-SHIFT -> sioc=1, siod=1, done=0, and no strobes for 10 cycles.
- start pulse -> first transaction bits sampled on sioc rises: 0x42,X, 0x12,X, 0x80,X; siod falls with sioc high (start) and rises with sioc high (stop); a WAIT of RESET_WAIT_CYC precedes the second transaction.
- Complete the table -> done=1 after exactly TABLE_LEN transactions. A second start while busy changes nothing.
- After done: vsync 1->0, then href=1 with p_clk bytes 0xF8, 0x1F, 0x07, 0xE0 -> pixel_valid pulses twice with 0xF81F and 0x07E0, each 3 clk after the second byte's p_clk edge.
- href drops after a single byte 0xAA, then the next line sends 0x12, 0x34 -> one pixel 0x1234 and no pixel containing 0xAA. Pixels sent before the first vsync fall after done produce no strobes.
- vsync rises after the line -> exactly one frame_done pulse. A vsync pulse before arming -> no pulse.

Source files
------------

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - OV7670 register table, SCCB id and FSM state types
// CAM_TEST_PATTERN_EN appends the colour-bar test pattern entries to the table.
package ov7670_pkg;

  localparam logic [7:0] SCCB_ID = 8'h42;
  localparam int IDX_W = 4;

`ifdef CAM_TEST_PATTERN_EN
  localparam int TABLE_LEN = 10;
`else
  localparam int TABLE_LEN = 8;
`endif

  typedef enum logic [2:0] {
    CFG_IDLE, CFG_LOAD, CFG_XFER, CFG_GAP, CFG_WAIT, CFG_DONE
  } cfg_state_t;

  typedef enum logic [1:0] {
    SCCB_IDLE, SCCB_START, SCCB_SHIFT, SCCB_STOP
  } sccb_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_entry_t;

  // Entry 0 is the soft reset; the sequencer waits after it before continuing.
  function automatic reg_entry_t table_entry(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return '{8'h12, 8'h80};
      4'd1:    return '{8'h12, 8'h04};
      4'd2:    return '{8'h40, 8'hD0};
      4'd3:    return '{8'h8C, 8'h00};
      4'd4:    return '{8'h3A, 8'h04};
      4'd5:    return '{8'h11, 8'h01};
      4'd6:    return '{8'h0C, 8'h04};
      4'd7:    return '{8'h3E, 8'h19};
`ifdef CAM_TEST_PATTERN_EN
      4'd8:    return '{8'h70, 8'h3A};
      4'd9:    return '{8'h71, 8'hB5};
`endif
      default: return '{8'h00, 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/sccb_writer.sv
// rtl/sccb_writer.sv - write-only SCCB master sending id, address and data phases
// Each bit spans four quarter periods (low, low, high, high); siod moves only in the second low quarter.
module sccb_writer #(
  parameter int QUARTER = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       ack,
  output logic       sioc,
  output logic       siod
);
  import ov7670_pkg::*;

  localparam int CNT_W = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  sccb_state_t      state, state_nxt;
  logic [CNT_W-1:0] q_cnt;
  logic [1:0]       qtr;
  logic [4:0]       bit_cnt;
  logic [26:0]      shreg;
  logic             tick, sioc_nxt, siod_nxt;

  assign tick = (q_cnt == CNT_W'(QUARTER - 1));
  assign busy = (state != SCCB_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SCCB_IDLE;
      q_cnt   <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sioc    <= 1'b1;
      siod    <= 1'b1;
    end else begin
      state <= state_nxt;
      sioc  <= sioc_nxt;
      siod  <= siod_nxt;
      if (state == SCCB_IDLE) begin
        q_cnt   <= '0;
        qtr     <= '0;
        bit_cnt <= '0;
        if (go) shreg <= {SCCB_ID, 1'b1, addr, 1'b1, data, 1'b1};
      end else begin
        q_cnt <= tick ? '0 : q_cnt + 1'b1;
        if (tick) begin
          qtr <= qtr + 2'd1;
          if (state == SCCB_SHIFT && qtr == 2'd3) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    sioc_nxt  = sioc;
    siod_nxt  = siod;
    case (state)
      SCCB_IDLE: begin
        sioc_nxt = 1'b1;
        siod_nxt = 1'b1;
        if (go) state_nxt = SCCB_START;
      end
      SCCB_START: begin
        sioc_nxt = ~qtr[1];
        siod_nxt = (qtr == 2'd0);
        if (tick && qtr == 2'd3) state_nxt = SCCB_SHIFT;
      end
      SCCB_SHIFT: begin
        sioc_nxt = qtr[1];
        if (qtr == 2'd1) siod_nxt = shreg[26];
        if (tick && qtr == 2'd3 && bit_cnt == 5'd26) state_nxt = SCCB_STOP;
      end
      SCCB_STOP: begin
        sioc_nxt = qtr[1];
        if (qtr == 2'd1) siod_nxt = 1'b0;
        if (qtr == 2'd3) siod_nxt = 1'b1;
        if (tick && qtr == 2'd3) begin
          state_nxt = SCCB_IDLE;
          ack       = 1'b1;
        end
      end
      default: state_nxt = SCCB_IDLE;
    endcase
  end

endmodule

// File: rtl/ov7670_camera_ctrl.sv
// rtl/ov7670_camera_ctrl.sv - OV7670 register-table sequencer and RGB565 pixel capture
// CAM_TEST_PATTERN_EN (table contents in ov7670_pkg) lengthens the configuration sequence.
module ov7670_camera_ctrl #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCCB_HZ        = 100_000,
  parameter int RESET_WAIT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        p_clk,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  p_data,
  output logic        sioc,
  output logic        siod,
  output logic        done,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_done
);
  import ov7670_pkg::*;

  localparam int QUARTER = CLK_HZ / (4 * SCCB_HZ);
  localparam int GAP_CYC = 4 * QUARTER;

  cfg_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wait_cnt;
  logic             start_q, start_rise, go, ack, busy;
  reg_entry_t       entry;

  assign entry      = table_entry(idx);
  assign start_rise = start & ~start_q;
  assign done       = (state == CFG_DONE);

  sccb_writer #(.QUARTER(QUARTER)) u_sccb (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .addr (entry.addr),
    .data (entry.data),
    .busy (busy),
    .ack  (ack),
    .sioc (sioc),
    .siod (siod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CFG_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      wait_cnt <= (state == CFG_GAP || state == CFG_WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if (start_rise && (state == CFG_IDLE || state == CFG_DONE))
        idx <= '0;
      else if ((state == CFG_GAP || state == CFG_WAIT) && state_nxt == CFG_LOAD)
        idx <= idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      CFG_IDLE, CFG_DONE: if (start_rise) state_nxt = CFG_LOAD;
      CFG_LOAD: begin
        if (!busy) begin
          go        = 1'b1;
          state_nxt = CFG_XFER;
        end
      end
      CFG_XFER: begin
        if (ack) begin
          if (idx == IDX_W'(TABLE_LEN - 1))           state_nxt = CFG_DONE;
          else if (entry.addr == 8'h12 && entry.data == 8'h80) state_nxt = CFG_WAIT;
          else                                          state_nxt = CFG_GAP;
        end
      end
      CFG_GAP:  if (wait_cnt == 32'(GAP_CYC - 1))        state_nxt = CFG_LOAD;
      CFG_WAIT: if (wait_cnt == 32'(RESET_WAIT_CYC - 1)) state_nxt = CFG_LOAD;
      default:  state_nxt = CFG_IDLE;
    endcase
  end

  // Camera pins: all chains equal length so p_data/href line up with the p_clk edge.
  logic [2:0] pclk_sync, vsync_sync;
  logic [1:0] href_sync;
  logic [7:0] data_s1, data_s2;
  logic       armed, byte_phase;
  logic [7:0] hi_byte;
  logic       pclk_rise, vsync_rise, vsync_fall;

  assign pclk_rise  = pclk_sync[1] & ~pclk_sync[2];
  assign vsync_rise = vsync_sync[1] & ~vsync_sync[2];
  assign vsync_fall = ~vsync_sync[1] & vsync_sync[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_sync   <= '0;
      vsync_sync  <= '0;
      href_sync   <= '0;
      data_s1     <= '0;
      data_s2     <= '0;
      armed       <= 1'b0;
      byte_phase  <= 1'b0;
      hi_byte     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pclk_sync   <= {pclk_sync[1:0], p_clk};
      vsync_sync  <= {vsync_sync[1:0], vsync};
      href_sync   <= {href_sync[0], href};
      data_s1     <= p_data;
      data_s2     <= data_s1;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (!done) begin
        armed      <= 1'b0;
        byte_phase <= 1'b0;
      end else begin
        if (vsync_fall) armed <= 1'b1;
        if (armed && vsync_rise) frame_done <= 1'b1;
        if (!href_sync[1]) begin
          byte_phase <= 1'b0;
        end else if (armed && pclk_rise) begin
          if (!byte_phase) begin
            hi_byte    <= data_s2;
            byte_phase <= 1'b1;
          end else begin
            pixel_data  <= {hi_byte, data_s2};
            pixel_valid <= 1'b1;
            byte_phase  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_camera_ctrl.sv
// tb/tb_ov7670_camera_ctrl.sv - self-checking bench for ov7670_camera_ctrl
// Honours CAM_TEST_PATTERN_EN for the expected register table.
module tb_ov7670_camera_ctrl;

  localparam int CLK_HZ         = 100_000_000;
  localparam int SCCB_HZ        = 12_500_000;
  localparam int RESET_WAIT_CYC = 200;
  localparam int Q              = CLK_HZ / (4 * SCCB_HZ);

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        p_clk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  p_data = 8'h00;
  logic        sioc, siod, done, pixel_valid, frame_done;
  logic [15:0] pixel_data;

  ov7670_camera_ctrl #(
    .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .RESET_WAIT_CYC(RESET_WAIT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p_clk(p_clk), .vsync(vsync),
    .href(href), .p_data(p_data), .sioc(sioc), .siod(siod), .done(done),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] ref_tab[$];

  // Bus monitor: decodes SCCB start/bits/stop and records pixel and frame strobes.
  logic [27:0] mon_bits = '0;
  int          mon_n = 0;
  bit          mon_in = 0;
  logic        p_sioc = 1'b1, p_siod = 1'b1;
  logic [27:0] tx_bits[$];
  int          tx_n[$], tx_start[$], tx_stop[$];
  logic [15:0] pix_obs[$], exp_pix[$];
  int          pix_cyc[$], exp_cyc[$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in = 0;
      mon_n  = 0;
    end else begin
      if (p_sioc && sioc && p_siod && !siod) begin
        mon_in = 1; mon_n = 0; mon_bits = '0;
        tx_start.push_back(cyc);
      end else if (mon_in && !p_sioc && sioc) begin
        mon_bits = {mon_bits[26:0], siod};
        mon_n++;
      end else if (mon_in && p_sioc && sioc && !p_siod && siod) begin
        tx_bits.push_back(mon_bits);
        tx_n.push_back(mon_n);
        tx_stop.push_back(cyc);
        mon_in = 0;
      end
      if (pixel_valid) begin
        pix_obs.push_back(pixel_data);
        pix_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
    end
    p_sioc = sioc;
    p_siod = siod;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    tx_bits.delete(); tx_n.delete(); tx_start.delete(); tx_stop.delete();
    pix_obs.delete(); pix_cyc.delete(); exp_pix.delete(); exp_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int edge_cyc);
    p_data = b;
    step(2);
    p_clk    = 1'b1;
    edge_cyc = cyc;
    step(2);
    p_clk = 1'b0;
  endtask

  // Reference: bytes pair up within a line; a trailing odd byte is lost; strobe 3 clk after the edge.
  task automatic send_line(input logic [7:0] bytes[$], input bit armed_m);
    int ec;
    href = 1'b1;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], ec);
      if (armed_m && (i % 2 == 1)) begin
        exp_pix.push_back({bytes[i-1], bytes[i]});
        exp_cyc.push_back(ec + 3);
      end
    end
    href = 1'b0;
    step(4);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step(6);
    vsync = 1'b0;
    step(6);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 20000) begin
      step(1);
      t++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(5);
    n_cmp++; if (sioc !== 1'b1)  begin n_bad++; $display("FAIL reset_sioc: got %b want 1", sioc); end
    n_cmp++; if (siod !== 1'b1)  begin n_bad++; $display("FAIL reset_siod: got %b want 1", siod); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (pixel_data !== 16'h0000) begin n_bad++; $display("FAIL reset_pixel_data: got %h want 0000", pixel_data); end
    n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
    n_cmp++; if (frame_done !== 1'b0)  begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid_shift();
    int t = 0;
    pulse_start();
    while (!(mon_in && mon_n >= 6) && t < 3000) begin
      step(1);
      t++;
    end
    n_cmp++;
    if (!(mon_in && mon_n >= 6)) begin
      n_bad++;
      $display("FAIL midshift_reach: bits seen %0d, want >= 6", mon_n);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_cmp++;
      if ({sioc, siod, done, pixel_valid, frame_done} !== 5'b11000) begin
        n_bad++;
        $display("FAIL midshift_reset_c%0d: sioc,siod,done,pv,fd=%b want 11000", i,
                 {sioc, siod, done, pixel_valid, frame_done});
      end
    end
    rst_n = 1'b1;
    step(4);
    clear_logs();
  endtask

  task automatic test_config();
    int t = 0;
    logic [27:0] b;
    int gap;
    pulse_start();
    while (tx_bits.size() < 1 && t < 2000) begin
      step(1);
      t++;
    end
    n_cmp++;
    if (tx_bits.size() < 1) begin
      n_bad++;
      $display("FAIL cfg_first_tx: transactions %0d want 1", tx_bits.size());
    end else begin
      b = tx_bits[0];
      n_cmp++;
      if ({b[27:20], b[18:11], b[9:2]} !== 24'h421280) begin
        n_bad++;
        $display("FAIL cfg_first_bytes: got %h want 421280", {b[27:20], b[18:11], b[9:2]});
      end
    end
    pulse_start();
    wait_done("cfg_done");
    n_cmp++;
    if (tx_stop.size() != ref_tab.size()) begin
      n_bad++;
      $display("FAIL cfg_done_count: stops %0d when done rose, want %0d", tx_stop.size(), ref_tab.size());
    end
    for (int i = 0; i < ref_tab.size() && i < tx_bits.size(); i++) begin
      b = tx_bits[i];
      n_cmp++;
      if (tx_n[i] != 28 || {b[27:20], b[18:11], b[9:2]} !== {8'h42, ref_tab[i]}) begin
        n_bad++;
        $display("FAIL cfg_tx%0d: bits %0d bytes %h want 28 bits bytes %h", i, tx_n[i],
                 {b[27:20], b[18:11], b[9:2]}, {8'h42, ref_tab[i]});
      end
    end
    for (int i = 1; i < ref_tab.size() && i < tx_start.size() && i <= tx_stop.size(); i++) begin
      gap = tx_start[i] - tx_stop[i-1];
      n_cmp++;
      if (ref_tab[i-1] == 16'h1280) begin
        if (gap < RESET_WAIT_CYC || gap > RESET_WAIT_CYC + 8 * Q + 8) begin
          n_bad++;
          $display("FAIL cfg_wait_gap%0d: got %0d want %0d..%0d", i, gap, RESET_WAIT_CYC, RESET_WAIT_CYC + 8 * Q + 8);
        end
      end else if (gap < 4 * Q || gap >= RESET_WAIT_CYC) begin
        n_bad++;
        $display("FAIL cfg_gap%0d: got %0d want %0d..%0d", i, gap, 4 * Q, RESET_WAIT_CYC - 1);
      end
    end
    step(60);
    n_cmp++;
    if (tx_start.size() != ref_tab.size() || done !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_busy_start_ignored: starts %0d done %b want %0d and 1", tx_start.size(), done, ref_tab.size());
    end
  endtask

  task automatic test_prearm();
    logic [7:0] q[$];
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pix_obs.delete(); pix_cyc.delete(); fd_cnt = 0;
    send_line(q, 1'b0);
    vsync_pulse();
    n_cmp++;
    if (pix_obs.size() != 0) begin
      n_bad++;
      $display("FAIL prearm_pixels: got %0d strobes want 0", pix_obs.size());
    end
    n_cmp++;
    if (fd_cnt != 0) begin
      n_bad++;
      $display("FAIL prearm_frame_done: got %0d want 0", fd_cnt);
    end
  endtask

  task automatic test_capture_directed();
    logic [7:0] q[$];
    pix_obs.delete(); pix_cyc.delete(); exp_pix.delete(); exp_cyc.delete(); fd_cnt = 0;
    q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    send_line(q, 1'b1);
    q = '{8'hAA};
    send_line(q, 1'b1);
    q = '{8'h12, 8'h34};
    send_line(q, 1'b1);
    vsync = 1'b1;
    step(6);
    n_cmp++;
    if (fd_cnt != 1) begin
      n_bad++;
      $display("FAIL dir_frame_done: got %0d pulse cycles want 1", fd_cnt);
    end
    vsync = 1'b0;
    step(6);
    n_cmp++;
    if (pix_obs.size() != 3) begin
      n_bad++;
      $display("FAIL dir_pixel_count: got %0d want 3", pix_obs.size());
    end
    for (int i = 0; i < exp_pix.size() && i < pix_obs.size(); i++) begin
      n_cmp++;
      if (pix_obs[i] !== exp_pix[i] || pix_cyc[i] != exp_cyc[i]) begin
        n_bad++;
        $display("FAIL dir_pixel%0d: got %h at cyc %0d want %h at cyc %0d", i, pix_obs[i], pix_cyc[i], exp_pix[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_capture_random();
    logic [7:0] q[$];
    int nfr = 0;
    pix_obs.delete(); pix_cyc.delete(); exp_pix.delete(); exp_cyc.delete(); fd_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < int'($urandom_range(2, 4)); l++) begin
        q.delete();
        for (int k = 0; k < int'($urandom_range(1, 9)); k++) q.push_back(8'($urandom_range(0, 255)));
        send_line(q, 1'b1);
      end
      vsync_pulse();
      nfr++;
    end
    n_cmp++;
    if (fd_cnt != nfr) begin
      n_bad++;
      $display("FAIL rnd_frame_done: got %0d want %0d", fd_cnt, nfr);
    end
    n_cmp++;
    if (pix_obs.size() != exp_pix.size()) begin
      n_bad++;
      $display("FAIL rnd_pixel_count: got %0d want %0d", pix_obs.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < pix_obs.size(); i++) begin
      n_cmp++;
      if (pix_obs[i] !== exp_pix[i] || pix_cyc[i] != exp_cyc[i]) begin
        n_bad++;
        $display("FAIL rnd_pixel%0d: got %h at cyc %0d want %h at cyc %0d", i, pix_obs[i], pix_cyc[i], exp_pix[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] q[$];
    logic [27:0] b;
    q = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    clear_logs();
    pulse_start();
    step(1);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_done_clear: got %b want 0", done);
    end
    send_line(q, 1'b0);
    vsync_pulse();
    wait_done("restart_done");
    n_cmp++;
    if (tx_bits.size() != ref_tab.size()) begin
      n_bad++;
      $display("FAIL restart_tx_count: got %0d want %0d", tx_bits.size(), ref_tab.size());
    end
    if (tx_bits.size() > 0) begin
      b = tx_bits[0];
      n_cmp++;
      if ({b[18:11], b[9:2]} !== 16'h1280) begin
        n_bad++;
        $display("FAIL restart_first_entry: got %h want 1280", {b[18:11], b[9:2]});
      end
    end
    send_line(q, 1'b0);
    n_cmp++;
    if (pix_obs.size() != 0 || fd_cnt != 0) begin
      n_bad++;
      $display("FAIL restart_disarmed: pixels %0d frames %0d want 0 and 0", pix_obs.size(), fd_cnt);
    end
  endtask

  initial begin
    ref_tab = '{16'h1280, 16'h1204, 16'h40D0, 16'h8C00, 16'h3A04, 16'h1101, 16'h0C04, 16'h3E19};
`ifdef CAM_TEST_PATTERN_EN
    ref_tab.push_back(16'h703A);
    ref_tab.push_back(16'h71B5);
`endif
    test_reset();
    test_reset_mid_shift();
    test_config();
    test_prearm();
    test_capture_directed();
    test_capture_random();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
